// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs symbolic instruction requests into
// MIPS-subset words and writes them sequentially into instruction memory,
// starting at a base address latched when a load session begins.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        op_sel_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              full_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    localparam logic [ADDR_W:0] MAX_C = (ADDR_W+1)'(MAX_WORDS);

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q, full_q, done_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       wdata_d;
    logic [ADDR_W:0]   count_inc;
    logic              accept, op_ok, cap_hit;

    assign in_ready_o = (state_q == S_ACTIVE) && (count_q < MAX_C);
    assign accept     = in_valid_i && in_ready_o;
    assign op_ok      = (op_sel_i < 4'd14);
    assign count_inc  = count_q + 1'b1;
    // Capacity is only consumed by words that are actually written.
    assign cap_hit    = accept && op_ok && (count_inc == MAX_C);

    // Field packing; fields an op does not use are forced to zero.
    always_comb begin
        wdata_d = 32'h0;
        case (op_sel_i)
            4'd0:  wdata_d = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100000};
            4'd1:  wdata_d = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100010};
            4'd2:  wdata_d = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100100};
            4'd3:  wdata_d = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100101};
            4'd4:  wdata_d = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b100110};
            4'd5:  wdata_d = {6'b000000, 5'd0, rt_i, rd_i, shamt_i, 6'b000000};
            4'd6:  wdata_d = {6'b000000, 5'd0, rt_i, rd_i, shamt_i, 6'b000010};
            4'd7:  wdata_d = {6'b000000, rs_i, rt_i, rd_i, 5'd0, 6'b011000};
            4'd8:  wdata_d = {6'b100011, rs_i, rt_i, imm_i};
            4'd9:  wdata_d = {6'b101011, rs_i, rt_i, imm_i};
            4'd10: wdata_d = {6'b000100, rs_i, rt_i, imm_i};
            4'd11: wdata_d = {6'b001000, rs_i, rt_i, imm_i};
            4'd12: wdata_d = {6'b000011, target_i};
            4'd13: wdata_d = {6'b000000, rs_i, 15'd0, 6'b001000};
            default: wdata_d = 32'h0;
        endcase
    end

    // Session FSM plus registered write port and status.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_ACTIVE;
                        base_q  <= base_addr_i;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        full_q  <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (accept && op_ok) begin
                        we_q    <= 1'b1;
                        addr_q  <= base_q + count_q[ADDR_W-1:0];
                        wdata_q <= wdata_d;
                        count_q <= count_inc;
                    end
                    if (accept && !op_ok)
                        err_q <= 1'b1;
                    if (cap_hit || finish_i) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        full_q  <= cap_hit;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = (state_q == S_ACTIVE);
    assign done_o       = done_q;
    assign full_o       = full_q;
    assign err_o        = err_q;
    assign word_count_o = count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the CPU's instruction decoder/control unit.
- Accepts symbolic instruction requests (operation + register/immediate fields) over a valid/ready handshake.
- Packs each request into the 32-bit MIPS-subset word the control unit decodes.
- Writes the words sequentially into instruction memory from a programmable base address; used by the bench/boot path to load programs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width
- MAX_WORDS, 256, maximum words per load session (1..2^ADDR_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a load session at base_addr
- base_addr  in  ADDR_W  first word address of the session
- finish  in  1  end the session
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- op_sel  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL, 8 LW, 9 SW, 10 BEQ, 11 ADDI, 12 JAL, 13 JR, 14-15 invalid
- rs, rt, rd, shamt  in  5 each  register/shift fields
- imm  in  16  I-type immediate, raw
- target  in  26  J-type target
- imem_we  out  1  memory write strobe
- imem_addr  out  ADDR_W  memory write address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- full  out  1  session ended by capacity
- err  out  1  sticky: an invalid op_sel was accepted
- word_count  out  ADDR_W+1  words written this session

Behaviour:
- Reset (rst_n low at a rising edge):
  - FSM goes to IDLE.
  - All outputs are 0; in_ready is 0.
  - A write pending from the previous cycle is dropped: imem_we is 0 in the cycle after the reset edge.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE --start--> ACTIVE. On that edge: latch base_addr, clear word_count, err and full.
  - ACTIVE --finish, or word_count reaching MAX_WORDS--> DONE.
  - DONE --start--> ACTIVE, with the same clearing as from IDLE.
  - start while ACTIVE is ignored. finish outside ACTIVE is ignored.
- Status outputs:
  - busy = (state == ACTIVE).
  - done pulses high for exactly one cycle, in the first cycle in DONE.
  - full is set with the capacity transition and holds until the next start or reset.
- in_ready = ACTIVE && word_count < MAX_WORDS.
  - It is combinational from state and count, not from in_valid.
- Accept at edge N with a valid op (0-13):
  - In the cycle after edge N: imem_we = 1, imem_addr = (base + word_count_before) mod 2^ADDR_W, imem_wdata = the encoding.
  - word_count increments at edge N. Latency is 1 cycle. Sustained throughput is 1 word/cycle.
  - imem_we is 0 in any cycle not preceded by an accept.
- Accept of an invalid op (14-15): no write, word_count unchanged, err set.
- finish and in_valid in the same ACTIVE cycle: the op is accepted and written (write occurs in the first DONE cycle), then the FSM goes to DONE.
- Encoding (opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]):
  - R-type, opcode 000000. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010, MUL 011000.
  - ADD..XOR and MUL: shamt field = 0.
  - SLL/SRL: rs field = 0, uses rt, rd, shamt.
  - JR: opcode 000000, rs, rt/rd/shamt = 0, funct 001000.
  - LW 100011, SW 101011, BEQ 000100, ADDI 001000: rs, rt, imm[15:0] passed unmodified.
  - JAL: opcode 000011, target[25:0].
  - Fields not used by an op are ignored from the inputs and encoded as 0.
- Address wrap: base + count wraps modulo 2^ADDR_W without error.

Test Plan:
- Reset mid-write:
  - start with base 0x10, ADD rs=1 rt=2 rd=3, assert rst_n=0 on the next edge → no write.
  - Without reset, the same sequence gives imem_we=1, addr 0x10, data 0x00221820, then all outputs 0.
- Back-to-back ops from base 0x00:
  - LW rt=8 rs=29 imm=4 → 0x8FA80004 at addr 0x00.
  - BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF at addr 0x01.
  - SLL rt=1 rd=2 shamt=4 → 0x00011100 at addr 0x02.
  - Writes land on consecutive cycles; word_count ends at 3.
- JAL target=0x10 → 0x0C000010; JR rs=31 → 0x03E00008.
  - finish in the same cycle as JR → JR is still written, then done pulses once and busy drops.
- Invalid op:
  - op_sel=14 → no write, err=1, word_count unchanged.
  - A following ADD is still written at the next address.
  - err stays 1 until the next start.
- Capacity and wrap, with MAX_WORDS=4, ADDR_W=8, base 0xFE:
  - Writes go to addresses 0xFE, 0xFF, 0x00, 0x01.
  - After the 4th accept: in_ready=0, full=1, done pulses.
- start during ACTIVE is ignored (base unchanged).
- start in DONE restarts: word_count=0, err=0, full=0.
